mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and its data-access (MEM-stage) requester.
- Sequences each memory transaction through a small FSM and supports variable memory latency.
- Produces if_stall and mem_stall so the pipeline holds its registers while a requester waits.
- Sits between the pipeline top level and the memory model. It replaces the separate instruction and data memory instances.

Parameters:
- AW, 32, address width in bits (byte address; word-aligned accesses only).
- DW, 32, data width in bits.
- MAX_D_STREAK, 3, maximum consecutive data grants while an instruction request is pending.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  AW  fetch address (the PC).
- i_ack  out  1  one-cycle pulse: i_rdata is valid.
- i_rdata  out  DW  fetched instruction word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address (ALU result).
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse: load data is valid, or the store has completed.
- d_rdata  out  DW  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid when m_ack = 1.
- m_ack  in  1  memory completion; may arrive in the same cycle as m_req or any later cycle.
- if_stall  out  1  combinational: i_req & ~i_ack.
- mem_stall  out  1  combinational: d_req & ~d_ack.

Behaviour:
- All outputs are registered except if_stall and mem_stall.
- Reset values: i_ack, d_ack, m_req, m_we = 0; i_rdata, d_rdata, m_addr, m_wdata = 0; d_streak = 0; state = IDLE.
- FSM states: IDLE, BUSY_I, BUSY_D, ACK.
- IDLE:
  - Requests are sampled only in this state.
  - If d_req=1 and (i_req=0 or d_streak<MAX_D_STREAK): grant data and go to BUSY_D.
  - Else if i_req=1: grant instruction and go to BUSY_I.
  - Else stay in IDLE.
  - On grant, the next cycle has m_req=1, with m_addr, m_we, m_wdata latched from the winner. m_we=0 for instruction grants.
- BUSY_I / BUSY_D:
  - m_req, m_addr, m_we, m_wdata are held stable until m_ack=1.
  - When m_ack=1: m_req←0; for reads, m_rdata is latched into i_rdata or d_rdata; go to ACK.
  - d_rdata is left unchanged on stores.
- ACK:
  - Exactly one of i_ack/d_ack is 1 for one cycle, then the FSM returns to IDLE.
  - The requester may drop or change its request from the following edge.
  - A request held through ACK is re-evaluated in IDLE.
- Latency: request seen in IDLE at cycle 0 → m_req high in cycle 1 → m_ack in cycle k≥1 → x_ack in cycle k+1. Minimum is 2 cycles; there is one idle bubble after each ack.
- Fairness counter d_streak:
  - Increments on a data grant made while i_req=1, saturating at MAX_D_STREAK.
  - Clears on any instruction grant, or in IDLE when i_req=0.
- Simultaneous events:
  - Both requests with d_streak<MAX: data wins, because the MEM-stage instruction is older.
  - Both requests with d_streak==MAX: instruction wins.
- m_ack outside BUSY_I/BUSY_D is ignored.
- i_addr and d_addr are not checked for alignment; bits [1:0] pass through unchanged.
- Reset mid-transaction: the transaction is aborted; m_req drops the next cycle; no ack is issued. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_ARB_IBUF_EN.
- Defined:
  - A single-entry instruction buffer holds {valid, addr, data}.
  - In IDLE, an instruction grant whose i_addr matches a valid buffer entry goes directly to ACK. It returns the buffered data without asserting m_req; latency is 1 cycle.
  - The buffer is filled on every completed instruction fetch.
  - A completed store to the buffered address clears valid.
  - Reset clears valid.
  - Fairness counting is unchanged: a buffer hit counts as an instruction grant.
- Undefined: every instruction fetch goes to memory; no buffer logic exists.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, BUSY_I, BUSY_D, ACK};
  - requester-ID constants REQ_I = 1'b0, REQ_D = 1'b1;
  - default width constants.
- Sub-module inst_line_buf (single-entry buffer with hit/fill/invalidate) is instantiated only under MEM_ARB_IBUF_EN.
- The FSM and fairness counter stay in the top module.

Test Plan:
- Instruction only: i_req=1, i_addr=0x10, memory returns 0x8C010004 with m_ack on the same cycle as m_req → m_req high at cycle 1, i_ack at cycle 2 with i_rdata=0x8C010004, if_stall=1 during cycles 0–1.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, then a load of 0x40 with 3-cycle memory latency → m_we=1 only during the store; d_rdata=0xDEADBEEF; each d_ack is a 1-cycle pulse.
- Contention: i_req and d_req held high continuously with MAX_D_STREAK=3 → grant order D,D,D,I,D,D,D,I; no requester starves.
- Reset mid-transaction: reset asserted while in BUSY_D with m_ack withheld → next cycle m_req=0, no d_ack, state IDLE; a later i_req completes normally.
- MEM_ARB_IBUF_EN: fetch 0x20 twice → second i_ack arrives 1 cycle after the request with no m_req. A store to 0x20 followed by a fetch of 0x20 → m_req is reasserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW           = 32;
    localparam int unsigned DEF_DW           = 32;
    localparam int unsigned DEF_MAX_D_STREAK = 3;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/inst_line_buf.sv
// Single-entry instruction buffer: {valid, addr, data} with hit lookup,
// fill on completed fetch and invalidate on a store to the held address.
// Only instantiated when MEM_ARB_IBUF_EN is defined.
module inst_line_buf
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_c,
    output logic [DW-1:0] rdata_o,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_data_i,
    input  logic          inval_i,
    input  logic [AW-1:0] inval_addr_i
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] data_q,  data_d;

    // Fill wins over invalidate; the arbiter never requests both together.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            addr_d  = fill_addr_i;
            data_d  = fill_data_i;
        end else if (inval_i && valid_q && (inval_addr_i == addr_q)) begin
            valid_d = 1'b0;
        end
    end

    // Buffer entry register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit_c   = valid_q && (lookup_addr_i == addr_q);
    assign rdata_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and
// the MEM-stage data requester. Data normally wins (older instruction); a
// streak counter forces an instruction grant after MAX_D_STREAK data grants.
// Optional macro MEM_ARB_IBUF_EN adds a single-entry instruction buffer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          if_stall,
    output logic          mem_stall
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          ib_hit_c;
    logic [DW-1:0] ib_rdata;

`ifdef MEM_ARB_IBUF_EN
    logic ib_fill_c;
    logic ib_inval_c;

    // Fill on every completed fetch; drop the entry when a store hits it.
    assign ib_fill_c  = (state_q == BUSY_I) && m_ack;
    assign ib_inval_c = (state_q == BUSY_D) && m_ack && m_we_q;

    inst_line_buf #(
        .AW (AW),
        .DW (DW)
    ) u_ibuf (
        .clk           (clk),
        .reset         (reset),
        .lookup_addr_i (i_addr),
        .hit_c         (ib_hit_c),
        .rdata_o       (ib_rdata),
        .fill_i        (ib_fill_c),
        .fill_addr_i   (m_addr_q),
        .fill_data_i   (m_rdata),
        .inval_i       (ib_inval_c),
        .inval_addr_i  (m_addr_q)
    );
`else
    assign ib_hit_c = 1'b0;
    assign ib_rdata = '0;
`endif

    // Next-state, grant decision, memory command and response capture.
    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (d_streak_q < STREAK_MAX))) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    // Below STREAK_MAX here, so the increment cannot overflow.
                    d_streak_d = i_req ? (d_streak_q + SW'(1)) : '0;
                end else if (i_req) begin
                    d_streak_d = '0;
                    if (ib_hit_c) begin
                        state_d   = ACK;
                        i_ack_d   = 1'b1;
                        i_rdata_d = ib_rdata;
                    end else begin
                        state_d   = BUSY_I;
                        m_req_d   = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                    end
                end else begin
                    d_streak_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    state_d = ACK;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            d_streak_q <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    assign if_stall  = i_req & ~i_ack_q;
    assign mem_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_ack, d_ack, m_req, m_we, if_stall, mem_stall;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef MEM_ARB_IBUF_EN
    localparam bit IBUF_ON = 1'b1;
`else
    localparam bit IBUF_ON = 1'b0;
`endif

    // Expected registered outputs for the current cycle.
    bit          e_i_ack, e_d_ack, e_m_req, e_m_we, txn_is_i;
    logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;
    int          streak;
    bit          b_valid;
    logic [31:0] b_addr, b_data;

    // Memory responder state.
    logic [31:0] mem [logic [31:0]];
    int          lat_cnt, lat_tgt;
    int          fixed_lat = -1;
    bit          pend, withhold, spurious;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic check_regs();
        chk1("i_ack", i_ack, e_i_ack);
        chk1("d_ack", d_ack, e_d_ack);
        chk1("m_req", m_req, e_m_req);
        chk1("m_we", m_we, e_m_we);
        chk32("i_rdata", i_rdata, e_i_rdata);
        chk32("d_rdata", d_rdata, e_d_rdata);
        if (e_m_req) begin
            chk32("m_addr", m_addr, e_m_addr);
            if (e_m_we) chk32("m_wdata", m_wdata, e_m_wdata);
        end
    endtask

    // Memory with configurable latency (0 = ack in the first m_req cycle).
    task automatic drive_mem();
        m_ack   = 1'b0;
        m_rdata = $urandom;
        if (m_req === 1'b1) begin
            if (!pend) begin
                pend    = 1'b1;
                lat_cnt = 0;
                lat_tgt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (!withhold && lat_cnt == lat_tgt) begin
                m_ack   = 1'b1;
                m_rdata = mem_rd(m_addr);
                if (m_we === 1'b1) mem[m_addr] = m_wdata;
                pend    = 1'b0;
            end else begin
                lat_cnt++;
            end
        end else begin
            pend = 1'b0;
            if (spurious && $urandom_range(0, 7) == 0) m_ack = 1'b1;
        end
    endtask

    // Transaction-level model: derive the next cycle from observable phase.
    task automatic model_step();
        if (reset) begin
            e_i_ack = 0; e_d_ack = 0; e_m_req = 0; e_m_we = 0;
            e_m_addr = 0; e_m_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
            streak = 0; b_valid = 0;
        end else if (e_i_ack || e_d_ack) begin
            e_i_ack = 0;
            e_d_ack = 0;
        end else if (e_m_req) begin
            if (m_ack) begin
                if (txn_is_i) begin
                    e_i_rdata = m_rdata;
                    e_i_ack   = 1;
                    b_valid   = 1;
                    b_addr    = e_m_addr;
                    b_data    = m_rdata;
                end else begin
                    if (!e_m_we) e_d_rdata = m_rdata;
                    else if (b_valid && b_addr == e_m_addr) b_valid = 0;
                    e_d_ack = 1;
                end
                e_m_req = 0;
                e_m_we  = 0;
            end
        end else begin
            if (d_req && (!i_req || streak < MAXS)) begin
                e_m_req   = 1;
                e_m_we    = d_we;
                e_m_addr  = d_addr;
                e_m_wdata = d_wdata;
                txn_is_i  = 0;
                streak    = i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else if (i_req) begin
                streak = 0;
                if (IBUF_ON && b_valid && b_addr == i_addr) begin
                    e_i_ack   = 1;
                    e_i_rdata = b_data;
                end else begin
                    e_m_req  = 1;
                    e_m_we   = 0;
                    e_m_addr = i_addr;
                    txn_is_i = 1;
                end
            end else begin
                streak = 0;
            end
        end
    endtask

    // Called just after a falling edge with this cycle's inputs already set.
    task automatic cycle();
        drive_mem();
        #1;
        chk1("if_stall", if_stall, i_req & ~e_i_ack);
        chk1("mem_stall", mem_stall, d_req & ~e_d_ack);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic wait_ack(input bit is_i, input int budget, input string nm, output int n);
        logic a;
        n = 0;
        a = is_i ? i_ack : d_ack;
        while (a !== 1'b1 && n < budget) begin
            cycle();
            n++;
            a = is_i ? i_ack : d_ack;
        end
        checks++;
        if (a !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no ack after %0d cycles, required within %0d", nm, n, budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int    n;
        byte   grants[$];
        string exp_order;
        bit    prev;

        reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; m_ack = 0; m_rdata = 0;
        withhold = 0; spurious = 0;
        mem[32'h10] = 32'h8C010004;
        mem[32'h20] = 32'h12345678;

        repeat (2) cycle();
        chk1("rst_i_ack", i_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk32("rst_m_addr", m_addr, 32'h0);
        chk32("rst_m_wdata", m_wdata, 32'h0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        reset = 0;

        // Instruction only, zero-latency memory.
        fixed_lat = 0; i_req = 1; i_addr = 32'h10;
        #1; chk1("t1_if_stall_c0", if_stall, 1'b1);
        cycle();
        chk1("t1_m_req_c1", m_req, 1'b1);
        chk32("t1_m_addr_c1", m_addr, 32'h10);
        chk1("t1_if_stall_c1", if_stall, 1'b1);
        chk1("t1_i_ack_c1", i_ack, 1'b0);
        cycle();
        chk1("t1_i_ack_c2", i_ack, 1'b1);
        chk32("t1_i_rdata", i_rdata, 32'h8C010004);
        chk1("t1_if_stall_c2", if_stall, 1'b0);
        i_req = 0;
        cycle();
        chk1("t1_i_ack_pulse", i_ack, 1'b0);

        // Store then load with three-cycle memory latency.
        fixed_lat = 2; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        cycle();
        chk1("t2_st_m_we", m_we, 1'b1);
        wait_ack(1'b0, 20, "t2_st", n);
        chk32("t2_st_latency", 32'(n), 32'd3);
        chk32("t2_mem_written", mem_rd(32'h40), 32'hDEADBEEF);
        d_we = 0; d_wdata = 0;
        cycle();
        chk1("t2_st_d_ack_pulse", d_ack, 1'b0);
        cycle();
        chk1("t2_ld_m_req", m_req, 1'b1);
        chk1("t2_ld_m_we", m_we, 1'b0);
        wait_ack(1'b0, 20, "t2_ld", n);
        chk32("t2_ld_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 0;
        cycle();
        chk1("t2_ld_d_ack_pulse", d_ack, 1'b0);

        // Contention: both held, expect D,D,D,I,D,D,D,I.
        fixed_lat = -1;
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h84;
        prev = 0;
        for (int c = 0; c < 300 && grants.size() < 8; c++) begin
            cycle();
            if (m_req === 1'b1 && !prev) grants.push_back((m_addr == 32'h84) ? 8'h44 : 8'h49);
            prev = (m_req === 1'b1);
        end
        exp_order = "DDDIDDDI";
        chk32("t3_grant_count", 32'(grants.size()), 32'd8);
        for (int k = 0; k < 8 && k < grants.size(); k++)
            chk32($sformatf("t3_grant_%0d", k), 32'(grants[k]), 32'(exp_order[k]));
        for (int c = 0; c < 100 && (i_req || d_req); c++) begin
            if (i_ack === 1'b1) i_req = 0;
            if (d_ack === 1'b1) d_req = 0;
            cycle();
        end

        // Reset while a load waits on withheld memory.
        withhold = 1; d_req = 1; d_we = 0; d_addr = 32'h44;
        repeat (3) cycle();
        chk1("t4_m_req_busy", m_req, 1'b1);
        reset = 1; d_req = 0;
        cycle();
        reset = 0;
        chk1("t4_m_req_dropped", m_req, 1'b0);
        chk1("t4_no_d_ack", d_ack, 1'b0);
        withhold = 0;
        cycle();
        chk1("t4_no_d_ack_late", d_ack, 1'b0);
        i_req = 1; i_addr = 32'h10;
        wait_ack(1'b1, 20, "t4_fetch", n);
        chk32("t4_i_rdata", i_rdata, 32'h8C010004);
        i_req = 0;
        cycle();

        // Repeated fetch of the same address, then store and refetch.
        i_req = 1; i_addr = 32'h20;
        wait_ack(1'b1, 20, "t5_fetch1", n);
        chk32("t5_fetch1_data", i_rdata, 32'h12345678);
        i_req = 0;
        cycle();
        i_req = 1;
        cycle();
`ifdef MEM_ARB_IBUF_EN
        chk1("t5_hit_i_ack", i_ack, 1'b1);
        chk1("t5_hit_no_m_req", m_req, 1'b0);
        chk32("t5_hit_data", i_rdata, 32'h12345678);
`else
        chk1("t5_refetch_goes_to_mem", m_req, 1'b1);
        wait_ack(1'b1, 20, "t5_fetch2", n);
`endif
        i_req = 0;
        cycle();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hA5A5A5A5;
        wait_ack(1'b0, 20, "t5_store", n);
        d_req = 0;
        cycle();
        i_req = 1; i_addr = 32'h20;
        cycle();
        chk1("t5_refetch_m_req", m_req, 1'b1);
        wait_ack(1'b1, 20, "t5_fetch3", n);
        chk32("t5_fetch3_data", i_rdata, 32'hA5A5A5A5);
        i_req = 0;
        cycle();

        // Randomized traffic with occasional resets and stray m_ack pulses.
        spurious = 1; fixed_lat = -1;
        for (int c = 0; c < 4000; c++) begin
            if (e_i_ack || !i_req) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 32'($urandom_range(0, 15));
            end
            if (e_d_ack || !d_req) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 0; i_req = 0; d_req = 0; spurious = 0;
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
